// File: rtl/game_ctrl.sv
// Game-flow controller: title -> ready countdown -> play -> game over.
// Drives the bird physics block, detects ground/ceiling/pipe collisions and
// keeps the current and best score.
module game_ctrl #(
    parameter int unsigned BIRD_X      = 100,
    parameter int unsigned BIRD_W      = 20,
    parameter int unsigned BIRD_H      = 20,
    parameter int unsigned PIPE_W      = 40,
    parameter int unsigned GAP_H       = 120,
    parameter int unsigned READY_TICKS = 8,
    parameter int unsigned OVER_TICKS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        pause,
    input  logic [10:0] y_coord,
    input  logic [10:0] pipe_x,
    input  logic [10:0] gap_y,
    output logic [1:0]  state,
    output logic        enable,
    output logic [7:0]  score,
    output logic [7:0]  hi_score,
    output logic        collide,
    output logic [3:0]  countdown
);

    localparam int unsigned TW = $clog2(OVER_TICKS + 1);

    // Geometry constants as 12-bit signed so every sum below stays signed
    localparam logic signed [11:0] BX   = 12'(BIRD_X);
    localparam logic signed [11:0] BW   = 12'(BIRD_W);
    localparam logic signed [11:0] BH   = 12'(BIRD_H);
    localparam logic signed [11:0] PW   = 12'(PIPE_W);
    localparam logic signed [11:0] GH   = 12'(GAP_H);
    localparam logic signed [11:0] CEIL = 12'sd485;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReady = 2'd1,
        StPlay  = 2'd2,
        StOver  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            start_q, pause_q;
    logic            paused_q, paused_d;
    logic [3:0]      countdown_q, countdown_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ahead_q, ahead_d;
    logic [7:0]      score_q, score_d;
    logic [7:0]      hi_q, hi_d;
    logic            collide_q, collide_d;

    logic            start_rise, pause_rise, tick_play, timer_done;
    logic signed [11:0] y_s, px_s, gy_s, bird_top;
    logic            ahead_now, overlap, v_miss, hit;

    assign start_rise = start & ~start_q;
    assign pause_rise = pause & ~pause_q;
    assign tick_play  = (state_q == StPlay) && frame_tick && !paused_q;
    assign timer_done = (timer_q == TW'(OVER_TICKS));

    // Sign-extend to 12 bits so offsets cannot overflow
    assign y_s      = {y_coord[10], y_coord};
    assign px_s     = {pipe_x[10], pipe_x};
    assign gy_s     = {gap_y[10], gap_y};
    assign bird_top = y_s + BH;

    assign ahead_now = (px_s + PW) > BX;
    assign overlap   = (px_s < (BX + BW)) && ahead_now;
    assign v_miss    = (y_s < gy_s) || (bird_top > (gy_s + GH));
    assign hit       = (y_s <= 12'sd0) || (bird_top >= CEIL) || (overlap && v_miss);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            paused_q    <= 1'b0;
            countdown_q <= '0;
            timer_q     <= '0;
            ahead_q     <= 1'b0;
            score_q     <= '0;
            hi_q        <= '0;
            collide_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            pause_q     <= pause;
            paused_q    <= paused_d;
            countdown_q <= countdown_d;
            timer_q     <= timer_d;
            ahead_q     <= ahead_d;
            score_q     <= score_d;
            hi_q        <= hi_d;
            collide_q   <= collide_d;
        end
    end

    // Next-state, scoring and collision logic
    always_comb begin
        state_d     = state_q;
        paused_d    = paused_q;
        countdown_d = countdown_q;
        timer_d     = timer_q;
        ahead_d     = ahead_q;
        score_d     = score_q;
        hi_d        = hi_q;
        collide_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                paused_d = 1'b0;
                if (start_rise) begin
                    state_d     = StReady;
                    countdown_d = 4'(READY_TICKS);
                    score_d     = '0;
                end
            end
            StReady: begin
                paused_d = 1'b0;
                if (frame_tick) begin
                    if (countdown_q == 4'd1) begin
                        state_d     = StPlay;
                        countdown_d = '0;
                        // Prime from the current pipe so entry never scores
                        ahead_d     = ahead_now;
                    end else begin
                        countdown_d = countdown_q - 4'd1;
                    end
                end
            end
            StPlay: begin
                if (pause_rise) paused_d = ~paused_q;
                if (tick_play) begin
                    if (hit) begin
                        // Collision wins over a same-tick score
                        state_d   = StOver;
                        collide_d = 1'b1;
                        timer_d   = '0;
                        paused_d  = 1'b0;
                        if (score_q > hi_q) hi_d = score_q;
                    end else begin
                        ahead_d = ahead_now;
                        if (ahead_q && !ahead_now && score_q != 8'hff) begin
                            score_d = score_q + 8'd1;
                        end
                    end
                end
            end
            StOver: begin
                paused_d = 1'b0;
                if (frame_tick && !timer_done) timer_d = timer_q + 1'b1;
                if (start_rise && timer_done) begin
                    state_d     = StReady;
                    countdown_d = 4'(READY_TICKS);
                    score_d     = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign state     = state_q;
    assign enable    = (state_q == StPlay) && !paused_q;
    assign score     = score_q;
    assign hi_score  = hi_q;
    assign collide   = collide_q;
    assign countdown = countdown_q;

endmodule
